// File: rtl/round_timer_pkg.sv
// round_timer_pkg
// Shared definitions for the round countdown timer: FSM state encoding,
// BCD digit limits, the default round length and the load-value check.
package round_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_EXPIRED = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;
  localparam logic [3:0] DEF_TENS = 4'd6;
  localparam logic [3:0] DEF_ONES = 4'd0;

  // A round length is usable only if both digits are legal BCD for a
  // mm:ss seconds field and the round is not zero seconds long.
  function automatic logic bcd_load_valid(input logic [3:0] t, input logic [3:0] o);
    return !((t > MAX_TENS) || (o > MAX_ONES) || ((t == 4'd0) && (o == 4'd0)));
  endfunction

endpackage

// File: rtl/round_timer_ctrl_tick_gen.sv
// tick_gen
// Free-running clock divider producing a one-cycle tick once every CLK_HZ
// enabled cycles. The count only advances while en is high, so a paused
// partial second is kept. clr restarts the count from zero.
// Optional: ROUND_TIMER_WARN_EN adds half_tick, a second compare at the
// midpoint of each second.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   en          : advance the divider this cycle
//   clr         : force the divider back to zero (wins over en)
//   tick        : high in the enabled cycle where the divider is CLK_HZ-1
//   half_tick   : (ROUND_TIMER_WARN_EN) high where the divider is CLK_HZ/2-1
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
`ifdef ROUND_TIMER_WARN_EN
  output logic half_tick,
`endif
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] div;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking writes here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div <= '0;
    end else if (en) begin
      div <= tick ? '0 : div + W'(1);
    end
  end

  assign tick = en && (div == LAST);

`ifdef ROUND_TIMER_WARN_EN
  localparam logic [W-1:0] HALF = (CLK_HZ >= 2) ? W'(CLK_HZ / 2 - 1) : '0;
  assign half_tick = en && (div == HALF);
`endif

endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl
// Round countdown sequencer: start / pause / resume / abort, BCD seconds
// countdown driven by an internal 1 Hz tick, completed-round counter and
// end-of-game flag. Digits feed the HEX decoders directly.
// Optional: ROUND_TIMER_WARN_EN adds the blinking last-9-seconds warn output.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, pause, resume    : command levels (priority start > pause > resume)
//   abort                   : back to IDLE from anywhere, clears round count
//   load_tens, load_ones    : BCD round length, sampled on start
//   tens, ones              : current BCD digits
//   running, paused         : state flags
//   time_out                : high in EXPIRED and DONE
//   expired_pulse           : one cycle, on reaching 00
//   round_num               : completed rounds
//   game_over               : high in DONE
//   warn                    : (ROUND_TIMER_WARN_EN) last-9-seconds indicator
module round_timer_ctrl
  import round_timer_pkg::*;
#(
  parameter int         CLK_HZ       = 50_000_000,
  parameter logic [3:0] DEFAULT_TENS = DEF_TENS,
  parameter logic [3:0] DEFAULT_ONES = DEF_ONES,
  parameter int         MAX_ROUNDS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       resume,
  input  logic       abort,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       paused,
  output logic       time_out,
  output logic       expired_pulse,
  output logic [3:0] round_num,
`ifdef ROUND_TIMER_WARN_EN
  output logic       warn,
`endif
  output logic       game_over
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  state_t     state, state_nx;
  logic [3:0] tens_nx, ones_nx, round_nx;
  logic       pulse_nx;
  logic       tick, div_clr, div_en, expire;

  // Divider runs only in RUNNING; abort and start both restart it.
  assign div_en = (state == ST_RUNNING);
  assign expire = tick && (tens == 4'd0) && (ones == 4'd1);

`ifdef ROUND_TIMER_WARN_EN
  logic half_tick;
`endif

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (div_en),
    .clr       (div_clr),
`ifdef ROUND_TIMER_WARN_EN
    .half_tick (half_tick),
`endif
    .tick      (tick)
  );

  // NOTE: every signal written below gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    tens_nx  = tens;
    ones_nx  = ones;
    round_nx = round_num;
    pulse_nx = 1'b0;
    div_clr  = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
      tens_nx  = DEFAULT_TENS;
      ones_nx  = DEFAULT_ONES;
      round_nx = '0;
      div_clr  = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_EXPIRED: begin
          if (start) begin
            state_nx = ST_RUNNING;
            div_clr  = 1'b1;
            if (bcd_load_valid(load_tens, load_ones)) begin
              tens_nx = load_tens;
              ones_nx = load_ones;
            end else begin
              tens_nx = DEFAULT_TENS;
              ones_nx = DEFAULT_ONES;
            end
          end
        end
        ST_RUNNING: begin
          if (expire) begin
            // Final second: land on 00 and close the round; a pause in the
            // same cycle loses to expiry.
            tens_nx  = 4'd0;
            ones_nx  = 4'd0;
            pulse_nx = 1'b1;
            round_nx = round_num + 4'd1;
            state_nx = (round_num + 4'd1 == MAX_R) ? ST_DONE : ST_EXPIRED;
          end else begin
            if (tick) begin
              if (ones != 4'd0) begin
                ones_nx = ones - 4'd1;
              end else if (tens != 4'd0) begin
                ones_nx = MAX_ONES;
                tens_nx = tens - 4'd1;
              end
            end
            if (pause) state_nx = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (resume) state_nx = ST_RUNNING;
        end
        ST_DONE: ;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

`ifdef ROUND_TIMER_WARN_EN
  // Blink phase restarts high on entry to the last 9 s (or on resume) and
  // flips at each half and full second while counting.
  logic warn_nx;
  always_comb begin
    warn_nx = 1'b0;
    if ((state_nx == ST_PAUSED) && (tens_nx == 4'd0)) begin
      warn_nx = 1'b1;
    end else if ((state_nx == ST_RUNNING) && (tens_nx == 4'd0)) begin
      if ((state == ST_RUNNING) && (tens == 4'd0)) begin
        warn_nx = (half_tick || tick) ? ~warn : warn;
      end else begin
        warn_nx = 1'b1;
      end
    end
  end
`endif

  // Flags are decoded from the next state and registered alongside it, so
  // every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tens          <= DEFAULT_TENS;
      ones          <= DEFAULT_ONES;
      round_num     <= '0;
      running       <= 1'b0;
      paused        <= 1'b0;
      time_out      <= 1'b0;
      expired_pulse <= 1'b0;
      game_over     <= 1'b0;
`ifdef ROUND_TIMER_WARN_EN
      warn          <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      tens          <= tens_nx;
      ones          <= ones_nx;
      round_num     <= round_nx;
      running       <= (state_nx == ST_RUNNING);
      paused        <= (state_nx == ST_PAUSED);
      time_out      <= (state_nx == ST_EXPIRED) || (state_nx == ST_DONE);
      expired_pulse <= pulse_nx;
      game_over     <= (state_nx == ST_DONE);
`ifdef ROUND_TIMER_WARN_EN
      warn          <= warn_nx;
`endif
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Testbench for round_timer_ctrl (CLK_HZ=4, MAX_ROUNDS=2).
// Reference model tracks remaining seconds as a plain integer, a cycle
// phase within the second, a mode code and a round count; digits are
// derived by /10 and %10.
module tb_round_timer_ctrl;

  localparam int CLK_HZ     = 4;
  localparam int MAX_ROUNDS = 2;

  logic       clk = 1'b0;
  logic       reset, start, pause, resume, abort;
  logic [3:0] load_tens, load_ones;
  logic [3:0] tens, ones, round_num;
  logic       running, paused, time_out, expired_pulse, game_over;
`ifdef ROUND_TIMER_WARN_EN
  logic       warn;
`endif

  round_timer_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .DEFAULT_TENS (4'd6),
    .DEFAULT_ONES (4'd0),
    .MAX_ROUNDS   (MAX_ROUNDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .resume        (resume),
    .abort         (abort),
    .load_tens     (load_tens),
    .load_ones     (load_ones),
    .tens          (tens),
    .ones          (ones),
    .running       (running),
    .paused        (paused),
    .time_out      (time_out),
    .expired_pulse (expired_pulse),
    .round_num     (round_num),
`ifdef ROUND_TIMER_WARN_EN
    .warn          (warn),
`endif
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3, M_DONE = 4;
  int m_mode, m_secs, m_phase, m_rounds;
  bit m_pulse;

  always @(posedge clk) begin
    int  lv;
    bit  tick_now;
    m_pulse = 1'b0;
    if (reset || abort) begin
      m_mode   = M_IDLE;
      m_secs   = 60;
      m_phase  = 0;
      m_rounds = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_EXP: if (start) begin
          lv = int'(load_tens) * 10 + int'(load_ones);
          m_mode  = M_RUN;
          m_phase = 0;
          m_secs  = (load_tens <= 5 && load_ones <= 9 && lv > 0) ? lv : 60;
        end
        M_RUN: begin
          tick_now = (m_phase == CLK_HZ - 1);
          m_phase  = tick_now ? 0 : m_phase + 1;
          if (tick_now) m_secs--;
          if (tick_now && m_secs == 0) begin
            m_pulse = 1'b1;
            m_rounds++;
            m_mode = (m_rounds == MAX_ROUNDS) ? M_DONE : M_EXP;
          end else if (pause) begin
            m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (resume) m_mode = M_RUN;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tens",          32'(tens),          32'(m_secs / 10));
      check("ones",          32'(ones),          32'(m_secs % 10));
      check("running",       32'(running),       32'(m_mode == M_RUN));
      check("paused",        32'(paused),        32'(m_mode == M_PAUSE));
      check("time_out",      32'(time_out),      32'(m_mode == M_EXP || m_mode == M_DONE));
      check("expired_pulse", 32'(expired_pulse), 32'(m_pulse));
      check("round_num",     32'(round_num),     32'(m_rounds));
      check("game_over",     32'(game_over),     32'(m_mode == M_DONE));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [3:0] t, input logic [3:0] o);
    load_tens = t;
    load_ones = o;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
  endtask

  task automatic lit_digits(input string name, input logic [3:0] t, input logic [3:0] o);
    check({name, "_tens"}, 32'(tens), 32'(t));
    check({name, "_ones"}, 32'(ones), 32'(o));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; resume = 1'b0; abort = 1'b0;
    load_tens = 4'd0; load_ones = 4'd0;
    cyc(2);
    reset  = 1'b0;
    cmp_en = 1'b1;
    lit_digits("rst", 4'd6, 4'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_round", 32'(round_num), 32'd0);

    // Countdown from 12 with tick spacing of CLK_HZ cycles
    do_start(4'd1, 4'd2);
    check("s12_running", 32'(running), 32'd1);
    lit_digits("s12_t0", 4'd1, 4'd2);
    cyc(4); lit_digits("s12_t4", 4'd1, 4'd1);
    cyc(4); lit_digits("s12_t8", 4'd1, 4'd0);
    cyc(4); lit_digits("s12_t12", 4'd0, 4'd9);
    do_abort();
    lit_digits("abort1", 4'd6, 4'd0);

    // One-second round expires
    do_start(4'd0, 4'd1);
    cyc(3);
    check("s01_pre_pulse", 32'(expired_pulse), 32'd0);
    cyc(1);
    lit_digits("s01_exp", 4'd0, 4'd0);
    check("s01_pulse", 32'(expired_pulse), 32'd1);
    check("s01_time_out", 32'(time_out), 32'd1);
    check("s01_round", 32'(round_num), 32'd1);
    cyc(1);
    check("s01_pulse_off", 32'(expired_pulse), 32'd0);

    // Invalid loads fall back to 60
    do_start(4'd7, 4'd10);
    lit_digits("bad7a", 4'd6, 4'd0);
    do_abort();
    do_start(4'd0, 4'd0);
    lit_digits("bad00", 4'd6, 4'd0);
    do_abort();

    // Pause with divider held at 2, resume, decrement two edges later
    do_start(4'd0, 4'd5);
    cyc(1);
    pause = 1'b1; cyc(1); pause = 1'b0;
    check("p_paused", 32'(paused), 32'd1);
    cyc(10);
    lit_digits("p_frozen", 4'd0, 4'd5);
    resume = 1'b1; cyc(1); resume = 1'b0;
    check("p_resumed", 32'(running), 32'd1);
    cyc(1); lit_digits("p_r1", 4'd0, 4'd5);
    cyc(1); lit_digits("p_r2", 4'd0, 4'd4);
    do_abort();

    // Two rounds end the game; start ignored in DONE
    do_start(4'd0, 4'd1); cyc(4);
    check("g_round1", 32'(round_num), 32'd1);
    do_start(4'd0, 4'd1); cyc(4);
    check("g_over", 32'(game_over), 32'd1);
    check("g_round2", 32'(round_num), 32'd2);
    do_start(4'd1, 4'd2);
    check("g_start_ign", 32'(running), 32'd0);
    lit_digits("g_hold", 4'd0, 4'd0);
    pause = 1'b1; resume = 1'b1; cyc(1); pause = 1'b0; resume = 1'b0;
    check("g_still_over", 32'(game_over), 32'd1);
    do_abort();
    check("g_abort_over", 32'(game_over), 32'd0);
    check("g_abort_round", 32'(round_num), 32'd0);
    lit_digits("g_abort", 4'd6, 4'd0);

    // Pause in the expiry tick cycle: expiry wins
    do_start(4'd0, 4'd1);
    cyc(3);
    pause = 1'b1; cyc(1); pause = 1'b0;
    check("pe_time_out", 32'(time_out), 32'd1);
    check("pe_paused", 32'(paused), 32'd0);
    check("pe_pulse", 32'(expired_pulse), 32'd1);

    // Reset mid-run
    do_start(4'd1, 4'd2);
    cyc(2);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("rr_running", 32'(running), 32'd0);
    check("rr_round", 32'(round_num), 32'd0);
    lit_digits("rr", 4'd6, 4'd0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      abort  = ($urandom_range(0, 79) == 0);
      start  = ($urandom_range(0, 11) == 0);
      pause  = ($urandom_range(0, 9) == 0);
      resume = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        load_tens = 4'($urandom_range(0, 15));
        load_ones = 4'($urandom_range(0, 15));
      end else begin
        load_tens = 4'($urandom_range(0, 1));
        load_ones = 4'($urandom_range(0, 9));
      end
      cyc(1);
    end
    reset = 1'b0; abort = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
